// File: rtl/write_logic_header_pkg.sv
// Shared definitions for the header buffer write path: default geometry
// and the frame-writer state encoding.
package write_logic_header_pkg;

  localparam int unsigned CHAR_WIDTH_DEF = 9;
  localparam int unsigned LINE_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DISCARD,
    ST_COMMIT
  } wr_state_t;

endpackage

// File: rtl/write_logic_header_if.sv
// 8-bit AXI-Stream byte channel feeding the header buffer writer.
interface write_logic_header_if;

  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tready;

  modport master (
    output s_tdata,
    output s_tvalid,
    output s_tlast,
    input  s_tready
  );

  modport slave (
    input  s_tdata,
    input  s_tvalid,
    input  s_tlast,
    output s_tready
  );

endinterface

// File: rtl/write_logic_header_counters.sv
// Char/line write pointers for the header buffer. A newline clears the char
// index and advances the line index, wrapping naturally at the last line.
module write_logic_counters
  import write_logic_header_pkg::*;
#(
  parameter int unsigned CHAR_WIDTH = CHAR_WIDTH_DEF,
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  char_incr,
  input  logic                  newline,
  output logic [CHAR_WIDTH-1:0] char_ptr,
  output logic [LINE_WIDTH-1:0] line_ptr,
  output logic                  char_last
);

  assign char_last = (char_ptr == '1);

  // Pointer update; newline takes priority over a char increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_ptr <= '0;
      line_ptr <= '0;
    end else if (newline) begin
      char_ptr <= '0;
      line_ptr <= line_ptr + 1'b1;
    end else if (char_incr) begin
      char_ptr <= char_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/write_logic_header.sv
// Header buffer write path: takes one AXI-Stream frame per line, writes it
// byte by byte, marks the last byte, and tracks committed line occupancy.
module write_logic_header
  import write_logic_header_pkg::*;
#(
  parameter int unsigned CHAR_WIDTH = CHAR_WIDTH_DEF,
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  write_logic_header_if.slave            s,
  input  logic                           rd_newline,
  output logic                           we_rgs,
  output logic [LINE_WIDTH+CHAR_WIDTH:0] wr_ptr_rgs,
  output logic [7:0]                     tdata_rgs,
  output logic                           tlastarray_cs_rgs,
  output logic [LINE_WIDTH:0]            lines_used,
  output logic                           ovf_flag
);

  localparam logic [LINE_WIDTH:0] LINES_FULL = {1'b1, {LINE_WIDTH{1'b0}}};

  wr_state_t             state_q, state_d;
  logic [LINE_WIDTH:0]   lines_used_q, lines_used_d;
  logic                  ready_q, ready_d;
  logic                  accept;
  logic                  write;
  logic                  mark_last;
  logic                  char_incr;
  logic                  newline;
  logic                  commit;
  logic                  set_ovf;
  logic [CHAR_WIDTH-1:0] char_ptr;
  logic [LINE_WIDTH-1:0] line_ptr;
  logic                  char_last;

  assign s.s_tready = ready_q;
  assign lines_used = lines_used_q;
  assign accept     = s.s_tvalid && ready_q;

  write_logic_counters #(
    .CHAR_WIDTH (CHAR_WIDTH),
    .LINE_WIDTH (LINE_WIDTH)
  ) u_counters (
    .clk       (clk),
    .rst_n     (rst),
    .char_incr (char_incr),
    .newline   (newline),
    .char_ptr  (char_ptr),
    .line_ptr  (line_ptr),
    .char_last (char_last)
  );

  // Frame FSM next state, write decode and occupancy/ready look-ahead.
  always_comb begin
    state_d      = state_q;
    write        = 1'b0;
    mark_last    = 1'b0;
    char_incr    = 1'b0;
    newline      = 1'b0;
    commit       = 1'b0;
    set_ovf      = 1'b0;
    lines_used_d = lines_used_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write     = 1'b1;
          char_incr = 1'b1;
          if (s.s_tlast) begin
            mark_last = 1'b1;
            state_d   = ST_COMMIT;
          end else begin
            state_d   = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (accept) begin
          write     = 1'b1;
          char_incr = 1'b1;
          if (s.s_tlast) begin
            mark_last = 1'b1;
            state_d   = ST_COMMIT;
          end else if (char_last) begin
            mark_last = 1'b1;
            set_ovf   = 1'b1;
            state_d   = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (accept && s.s_tlast) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        newline = 1'b1;
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case ({commit, rd_newline})
      2'b10:   lines_used_d = lines_used_q + 1'b1;
      2'b01:   if (lines_used_q != '0) lines_used_d = lines_used_q - 1'b1;
      default: lines_used_d = lines_used_q;
    endcase

    // Ready is registered, so it is computed from the state and occupancy
    // that will hold in the next cycle.
    if (state_d == ST_IDLE) begin
      ready_d = (lines_used_d < LINES_FULL);
    end else begin
      ready_d = (state_d != ST_COMMIT);
    end
  end

  // FSM state, ready, occupancy and sticky overflow registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      lines_used_q <= '0;
      ovf_flag     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      lines_used_q <= lines_used_d;
      if (set_ovf) begin
        ovf_flag <= 1'b1;
      end
    end
  end

  // Registered buffer write port: one-cycle strobe per written byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_rgs            <= 1'b0;
      tlastarray_cs_rgs <= 1'b0;
      tdata_rgs         <= '0;
      wr_ptr_rgs        <= '0;
    end else begin
      we_rgs            <= write;
      tlastarray_cs_rgs <= write && mark_last;
      if (write) begin
        tdata_rgs  <= s.s_tdata;
        wr_ptr_rgs <= {1'b0, line_ptr, char_ptr};
      end
    end
  end

endmodule

// File: tb/tb_write_logic_header.sv
// Bench for write_logic_header: drives frames through the stream interface
// and compares buffer writes and occupancy against a frame-level model.
module tb_write_logic_header;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_newline = 1'b0;
  logic        we_rgs;
  logic [12:0] wr_ptr_rgs;
  logic [7:0]  tdata_rgs;
  logic        tlastarray_cs_rgs;
  logic [3:0]  lines_used;
  logic        ovf_flag;

  write_logic_header_if axis ();

  write_logic_header #(
    .CHAR_WIDTH (9),
    .LINE_WIDTH (3)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s                 (axis),
    .rd_newline        (rd_newline),
    .we_rgs            (we_rgs),
    .wr_ptr_rgs        (wr_ptr_rgs),
    .tdata_rgs         (tdata_rgs),
    .tlastarray_cs_rgs (tlastarray_cs_rgs),
    .lines_used        (lines_used),
    .ovf_flag          (ovf_flag)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  logic [21:0] obs_q[$];
  logic [21:0] exp_q[$];
  logic [7:0]  fdata [0:1023];

  int unsigned m_line = 0;
  int unsigned m_used = 0;
  bit          m_ovf  = 1'b0;

  // Write monitor: every strobe is captured as {ptr, data, last}.
  always @(posedge clk) begin
    #1;
    if (we_rgs === 1'b1) obs_q.push_back({wr_ptr_rgs, tdata_rgs, tlastarray_cs_rgs});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Expected writes of one frame: capped at 512 bytes per line.
  task automatic model_frame(input int unsigned len, input bit complete);
    int unsigned nw;
    logic [2:0]  ln;
    nw = (len > 512) ? 512 : len;
    ln = m_line[2:0];
    for (int unsigned i = 0; i < nw; i++) begin
      logic [8:0] ch;
      ch = i[8:0];
      exp_q.push_back({1'b0, ln, ch, fdata[i], (complete && (i == nw - 1))});
    end
    if (complete) begin
      if (len > 512) m_ovf = 1'b1;
      m_line = (m_line + 1) % 8;
    end
  endtask

  task automatic compare_writes(input string tag);
    int unsigned n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++) check(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic fill_random(input int unsigned len);
    for (int unsigned i = 0; i < len; i++) fdata[i] = 8'($urandom_range(0, 255));
  endtask

  // gap: 0 continuous, 1 alternate valid, 2 random. abort>0 stops mid-frame.
  task automatic send_frame(input int unsigned len, input int unsigned gap,
                            input bit rd_at_commit, input int unsigned abort);
    int unsigned sent, idle, stop;
    bit tog, vld;
    sent = 0; idle = 0; tog = 1'b1;
    stop = (abort != 0) ? abort : len;
    while (sent < stop) begin
      @(negedge clk);
      case (gap)
        0:       vld = 1'b1;
        1:       begin vld = tog; tog = ~tog; end
        default: vld = ($urandom_range(0, 2) != 0);
      endcase
      axis.s_tvalid = vld;
      axis.s_tdata  = fdata[sent];
      axis.s_tlast  = (sent == len - 1);
      if (vld && axis.s_tready) begin
        sent++;
        idle = 0;
      end else begin
        idle++;
        if (idle > 200) break;
      end
    end
    check("beats_accepted", sent, stop);
    @(negedge clk);
    axis.s_tvalid = 1'b0;
    axis.s_tlast  = 1'b0;
    if (abort != 0) begin
      model_frame(abort, 1'b0);
      compare_writes("wr_partial");
      return;
    end
    rd_newline = rd_at_commit;
    check("used_before_commit", lines_used, m_used);
    model_frame(len, 1'b1);
    m_used = m_used + 1 - (rd_at_commit ? 1 : 0);
    @(negedge clk);
    rd_newline = 1'b0;
    check("used_after_commit", lines_used, m_used);
    check("ovf_flag", ovf_flag, m_ovf);
    check("ready_idle", axis.s_tready, (m_used < 8));
    compare_writes("wr_beat");
  endtask

  task automatic rd_pulse();
    @(negedge clk);
    rd_newline = 1'b1;
    if (m_used > 0) m_used--;
    @(negedge clk);
    rd_newline = 1'b0;
    check("used_after_rd", lines_used, m_used);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_we", we_rgs, 0);
    check("rst_ptr", wr_ptr_rgs, 0);
    check("rst_tdata", tdata_rgs, 0);
    check("rst_tlast", tlastarray_cs_rgs, 0);
    check("rst_used", lines_used, 0);
    check("rst_ovf", ovf_flag, 0);
    check("rst_ready", axis.s_tready, 0);
    m_line = 0; m_used = 0; m_ovf = 1'b0;
    obs_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", axis.s_tready, 1);
  endtask

  initial begin
    axis.s_tvalid = 1'b0;
    axis.s_tlast  = 1'b0;
    axis.s_tdata  = '0;
    #3;
    do_reset();

    // Read pulse with nothing committed is ignored.
    rd_pulse();

    // Single 60-byte frame with ascending data.
    for (int unsigned i = 0; i < 60; i++) fdata[i] = 8'(i);
    send_frame(60, 0, 1'b0, 0);

    do_reset();

    // Eight one-byte frames fill every line.
    for (int unsigned f = 0; f < 8; f++) begin
      fill_random(1);
      send_frame(1, 0, 1'b0, 0);
    end
    check("used_full", lines_used, m_used);
    @(negedge clk);
    axis.s_tvalid = 1'b1;
    axis.s_tlast  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("ready_when_full", axis.s_tready, 0);
    end
    axis.s_tvalid = 1'b0;
    axis.s_tlast  = 1'b0;
    check("no_write_when_full", obs_q.size(), 0);
    rd_pulse();
    fill_random(1);
    send_frame(1, 0, 1'b0, 0);
    repeat (8) rd_pulse();

    // Oversized frame: truncated at char 511, tail discarded.
    fill_random(600);
    send_frame(600, 0, 1'b0, 0);
    fill_random(20);
    send_frame(20, 2, 1'b0, 0);

    // Commit coinciding with a read at three lines used.
    fill_random(3);
    send_frame(3, 0, 1'b0, 0);
    check("used_three", lines_used, 3);
    fill_random(5);
    send_frame(5, 0, 1'b1, 0);

    // Valid toggling every cycle.
    fill_random(10);
    send_frame(10, 1, 1'b0, 0);

    // Random frames with random gaps and reads.
    repeat (6) begin
      int unsigned len;
      if (m_used == 8) rd_pulse();
      len = $urandom_range(1, 40);
      fill_random(len);
      send_frame(len, 2, 1'($urandom_range(0, 1)), 0);
    end

    // Reset in the middle of a frame.
    if (m_used == 8) rd_pulse();
    fill_random(20);
    send_frame(20, 0, 1'b0, 5);
    do_reset();
    fill_random(8);
    send_frame(8, 2, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Absolute time guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/write_logic_header.md
Name: write_logic_header

Overview:
- Write-side counterpart of the header read path.
- Accepts an 8-bit AXI-Stream frame and writes it byte-by-byte into the line-organised header buffer (2^LINE_WIDTH lines x 2^CHAR_WIDTH bytes).
- Marks each frame's last byte in the tlast array and publishes line occupancy to the reader.
- Frees lines when the reader issues rd_newline.

Parameters:
- CHAR_WIDTH, 9, byte-index width per line (512 bytes/line).
- LINE_WIDTH, 3, line-index width (8 lines).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- s_tdata  input  8  stream byte.
- s_tvalid  input  1  byte valid.
- s_tlast  input  1  last byte of frame.
- s_tready  output  1  block can accept a byte.
- rd_newline  input  1  reader finished a line; frees one line (single-cycle pulse).
- we_rgs  output  1  buffer byte write strobe.
- wr_ptr_rgs  output  13  {1'b0, line[LINE_WIDTH-1:0], char[CHAR_WIDTH-1:0]}.
- tdata_rgs  output  8  byte to write.
- tlastarray_cs_rgs  output  1  with we_rgs, also records this char index as the line's last byte.
- lines_used  output  LINE_WIDTH+1  committed, unread lines (0..8).
- ovf_flag  output  1  sticky; frame exceeded line capacity. Cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; line and char pointers=0; lines_used=0; s_tready=0; we_rgs=0; tlastarray_cs_rgs=0; tdata_rgs=0; wr_ptr_rgs=0; ovf_flag=0.
- A beat is accepted when s_tvalid && s_tready.
- Outputs we_rgs, tdata_rgs, wr_ptr_rgs and tlastarray_cs_rgs are registered: an accepted beat appears on them exactly 1 cycle later, for 1 cycle.
- IDLE:
  - s_tready = (lines_used < 2^LINE_WIDTH).
  - First accepted beat goes to char 0 of the current line; go to FILL, or to COMMIT if that beat has s_tlast.
- FILL:
  - s_tready=1. Each accepted beat is written at the current char, then char increments.
  - Beat with s_tlast: written with tlastarray_cs_rgs=1; go to COMMIT.
  - Beat at char = 2^CHAR_WIDTH-1 without s_tlast: written with tlastarray_cs_rgs=1 (truncation point); set ovf_flag; go to DISCARD.
- DISCARD:
  - s_tready=1; accepted beats are dropped (no we_rgs).
  - Beat with s_tlast: go to COMMIT.
- COMMIT (1 cycle):
  - s_tready=0; char=0; line increments modulo 2^LINE_WIDTH (7 wraps to 0); lines_used+1; go to IDLE.
- lines_used update:
  - +1 on COMMIT; -1 on rd_newline.
  - Both in the same cycle: unchanged.
  - rd_newline when lines_used=0 and no commit: ignored (no underflow).
  - lines_used never exceeds 2^LINE_WIDTH, because s_tready stays low in IDLE while the buffer is full.
- Minimum frame cost: 1 byte plus 1 COMMIT cycle, so 2 cycles per 1-byte frame.
- s_tvalid low mid-frame: state and pointers hold; no write.
- Reset mid-frame: the partial frame is lost; the buffer content is not cleared, only the pointers and counters.

Decomposition:
- Shared package: CHAR_WIDTH/LINE_WIDTH defaults and the state encoding (IDLE, FILL, DISCARD, COMMIT).
- One natural sub-module: write_logic_counters. It holds the char/line pointers with char_incr, newline and wrap, mirroring the reader-side counters.
- FSM, occupancy counter and output registers stay in the top module.

Test Plan:
- Single frame: 60 bytes 0x00..0x3B, tlast on byte 59 -> 60 we_rgs pulses at wr_ptr 0x000..0x03B. tlastarray_cs_rgs=1 only at 0x03B. lines_used 0->1 one cycle after the COMMIT cycle.
- Line wrap: 9 one-byte frames, with rd_newline pulsed once after the 8th commit -> frames 1-8 go to lines 0..7 (wr_ptr 0x000, 0x200, ..., 0xE00). s_tready=0 while lines_used=8. After rd_newline, the 9th frame is written at wr_ptr 0x000 and lines_used returns to 8.
- Overflow: 600-byte frame -> 512 writes, tlastarray_cs_rgs at char 511. Bytes 512..599 accepted but not written. ovf_flag=1. Next frame starts at the next line, char 0.
- Simultaneous commit and rd_newline with lines_used=3 -> lines_used stays 3. rd_newline at lines_used=0 -> stays 0.
- Backpressure/gaps: s_tvalid toggled 1/0 every cycle over a 10-byte frame -> exactly 10 writes at consecutive chars, no duplicates or skips.
- Reset mid-frame: assert rst after byte 5 of a frame -> all outputs 0 immediately (asynchronous). After release, the next frame writes from wr_ptr 0x000.
